// File: rtl/imm_gen_pipe_if.sv
// Decode-stage handshake bundle: instruction in, extended immediate out.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  modport master (output in_valid, instr, out_ready,
                  input  in_ready, out_valid, imm, fmt, illegal);
  modport slave  (input  in_valid, instr, out_ready,
                  output in_ready, out_valid, imm, fmt, illegal);
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: combinational opcode decode feeding a 2-entry
// output buffer so a single stalled cycle downstream costs no throughput.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit SHAMT_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  imm_gen_pipe_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_IU   = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Every format is first assembled as a 32-bit value, then widened to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0] ins;
  logic [2:0]  f3;
  logic        is_shift;
  dec_t        dec;

  assign ins      = bus.instr;
  assign f3       = ins[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec = '{imm: '0, fmt: FMT_NONE, illegal: 1'b1};
    case (ins[6:0])
      OP_LOAD, OP_JALR: begin
        dec.imm     = sext32({{20{ins[31]}}, ins[31:20]});
        dec.fmt     = FMT_I;
        dec.illegal = 1'b0;
      end
      OP_IMM: begin
        dec.illegal = 1'b0;
        if (is_shift) begin
          dec.fmt = FMT_IU;
          if (XLEN == 64) dec.imm = XLEN'(ins[25:20]);
          else            dec.imm = XLEN'(ins[24:20]);
          // RV32 shamt is 5 bits; bit 25 set is a reserved encoding.
          dec.illegal = SHAMT_CHECK && (XLEN == 32) && ins[25];
        end else begin
          dec.imm = sext32({{20{ins[31]}}, ins[31:20]});
          dec.fmt = FMT_I;
        end
      end
      OP_SYSTEM: begin
        dec.fmt     = FMT_IU;
        dec.illegal = 1'b0;
        dec.imm     = f3[2] ? XLEN'(ins[19:15]) : XLEN'(ins[31:20]);
      end
      OP_STORE: begin
        dec.imm     = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
        dec.fmt     = FMT_S;
        dec.illegal = 1'b0;
      end
      OP_BRANCH: begin
        dec.imm     = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        dec.fmt     = FMT_B;
        dec.illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm     = sext32({ins[31:12], 12'b0});
        dec.fmt     = FMT_U;
        dec.illegal = 1'b0;
      end
      OP_JAL: begin
        dec.imm     = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        dec.fmt     = FMT_J;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  // Output buffer: in_ready comes from count only, never from out_ready.
  logic       hd, tl;
  logic [1:0] cnt;
  logic       push, pop;
  dec_t       mem [2];
  dec_t       head;

  assign bus.in_ready  = (cnt != 2'd2);
  assign bus.out_valid = (cnt != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd  <= 1'b0;
      tl  <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      hd  <= 1'b0;
      tl  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) tl <= ~tl;
      if (pop)  hd <= ~hd;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: an empty buffer masks its contents below.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tl] <= dec;
  end

  assign head        = bus.out_valid ? mem[hd] : '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
  assign bus.imm     = head.imm;
  assign bus.fmt     = head.fmt;
  assign bus.illegal = head.illegal;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator for the decode stage. It accepts raw 32-bit instructions over a valid/ready handshake and decodes the immediate format from the opcode. No external select input is used. It produces a sign- or zero-extended immediate of width XLEN, together with a format code and an illegal flag, through a 2-entry output buffer. The buffer gives full throughput and absorbs one cycle of downstream stall without dropping data. A synchronous flush input discards buffered work on a pipeline redirect.

## Interface
- XLEN, 32: immediate width. Legal values are 32 and 64.
- SHAMT_CHECK, 1: when 1, an OP-IMM shift with XLEN=32 and instr[25]=1 is flagged illegal.

- clk  in  1  Single clock. All state updates on the rising edge.
- rst_n  in  1  Reset. Asynchronous assert, active-low.
- flush  in  1  Synchronous clear of the buffer.
- in_valid  in  1  Instruction present.
- in_ready  out  1  The block can accept an instruction.
- instr  in  32  Raw instruction word.
- out_valid  out  1  The head entry is valid.
- out_ready  in  1  Consumer accepts the head entry.
- imm  out  XLEN  Extended immediate of the head entry.
- fmt  out  3  Format of the head entry: 0=I, 1=I-unsigned, 2=S, 3=B, 4=U, 5=J, 7=none.
- illegal  out  1  The head opcode has no immediate decode.

## Operation
Opcode decode uses instr[6:0]:
- **I-type (fmt 0):** LOAD 0000011, JALR 1100111, OP-IMM 0010011 with funct3 not 001 or 101. imm = sext(instr[31:20]).
- **OP-IMM shifts (fmt 1):** OP-IMM with funct3 001 or 101.
  - XLEN=32: imm = zext(instr[24:20]).
  - XLEN=64: imm = zext(instr[25:20]).
- **SYSTEM 1110011 (fmt 1):** funct3[2]=1 gives imm = zext(instr[19:15]) (CSR zimm). Otherwise imm = zext(instr[31:20]).
- **STORE 0100011 (fmt 2):** imm = sext({instr[31:25], instr[11:7]}).
- **BRANCH 1100011 (fmt 3):** imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- **LUI 0110111, AUIPC 0010111 (fmt 4):** imm = sext({instr[31:12], 12'b0}). Sign extension applies when XLEN=64.
- **JAL 1101111 (fmt 5):** imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- **Any other opcode:** imm=0, fmt=7, illegal=1.
- **Illegal shift:** a shift with SHAMT_CHECK=1, XLEN=32 and instr[25]=1 keeps its fmt 1 decode but sets illegal=1.

Decode is combinational on instr. The result {imm, fmt, illegal} is written into the buffer.

Buffer:
- 2 entries, with head/tail pointers (1 bit each) and a count of 0..2.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != 2). in_ready depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). The outputs always show the head entry.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
  - A push with count=2 is impossible, because in_ready=0.
  - A pop with count=0 is ignored.
- **Flush:** count ← 0 and both pointers ← 0. A push in the same cycle is discarded, and any pop in that cycle is void.
- **Empty buffer:** head contents are don't-care for storage. The outputs are forced to imm=0, fmt=7, illegal=0 whenever out_valid=0.
- **Pointer wrap:** the 1-bit pointers wrap naturally.

## Timing
- **Reset (async, rst_n=0):** count=0 and pointers=0, giving out_valid=0, in_ready=1, imm=0, fmt=7, illegal=0.
- **Reset mid-operation:** all buffered entries are lost immediately, without waiting for a clock edge.
- **Latency:** an instruction accepted at edge N is presented with out_valid=1 from edge N until it is popped. That is 1 cycle of latency.
- **Throughput:** with out_ready held at 1, one instruction per cycle, sustained.
- **Stall:** when out_ready=0, at most 2 entries are absorbed. in_ready falls on the edge that makes count=2.
- **Output stability:** while out_valid=1 and out_ready=0, imm, fmt and illegal must stay stable.

## Test plan
- **Reset and single accept:** release reset, then push 0xFFF00093 (addi x1,x0,-1). Required: one cycle later out_valid=1, imm=0xFFFFFFFF, fmt=0, illegal=0.
- **Format sweep at XLEN=32, out_ready=1:**
  - 0x123450B7 → imm 0x12345000, fmt 4.
  - 0xFE000EE3 → imm 0xFFFFFFFC, fmt 3.
  - 0x000FD073 → imm 0x0000001F, fmt 1.
  - 0x0000007F → imm 0, fmt 7, illegal=1.
  - All four appear on consecutive cycles.
- **XLEN=64 variant:**
  - 0x800000B7 → imm 0xFFFFFFFF80000000.
  - 0x03F01093 (slli x1,x0,63) → imm 0x3F, fmt 1, illegal=0.
  - The same slli at XLEN=32 must set illegal=1.
- **Backpressure:** out_ready=0 while pushing A, B, C on consecutive cycles.
  - Required: A and B are accepted, in_ready=0 after the second push, and C is held.
  - Then out_ready=1 drains A, B, C in order, with no loss or duplication.
- **Simultaneous push/pop at count=1:** count stays 1 and order is preserved.
- **Flush and async reset:** with count=2, assert flush together with in_valid. Required: next cycle out_valid=0, in_ready=1, and the new instruction is dropped. Then asserting rst_n=0 mid-stream clears out_valid immediately.
